// File: rtl/conv_window_reader.sv
// Read-side controller for a bank of buff_size pixel line buffers.
// Counts completed rows from upstream, tracks the buffer holding the oldest
// row, sweeps the shared read address across the row and hands out
// buff_size x buff_size windows over a valid/ready handshake.
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   row_done_i       pulse: upstream finished a row into buffer row_wsel_o
//   rows_i           per-buffer pixels at read_address_o + buff_size-1-i
//   read_address_o   left column of the current window
//   row_wsel_o       buffer index upstream must write next
//   row_free_o       pulse: oldest buffer released
//   window_o         window_o[r][c], r=0 oldest row, c=0 leftmost column
//   window_valid_o   window_o holds an unaccepted window
//   window_ready_i   downstream accepts on valid & ready
//   frame_done_o     pulse after the last window of a frame is captured
//   overflow_o       sticky: row_done_i arrived while all buffers were full
module conv_window_reader #(
  parameter int unsigned input_width = 8,
  parameter int unsigned buff_size   = 3,
  parameter int unsigned im_dim      = 28
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_i,
  input  logic                                                   row_done_i,
  input  logic [buff_size-1:0][buff_size-1:0][input_width-1:0]   rows_i,
  output logic [$clog2(im_dim)-1:0]                              read_address_o,
  output logic [$clog2(buff_size)-1:0]                           row_wsel_o,
  output logic                                                   row_free_o,
  output logic [buff_size-1:0][buff_size-1:0][input_width-1:0]   window_o,
  output logic                                                   window_valid_o,
  input  logic                                                   window_ready_i,
  output logic                                                   frame_done_o,
  output logic                                                   overflow_o
);

  localparam int unsigned AW = $clog2(im_dim);
  localparam int unsigned SW = $clog2(buff_size);
  localparam int unsigned CW = $clog2(buff_size + 1);

  localparam logic [AW-1:0] LAST_POS = AW'(im_dim - buff_size);
  localparam logic [CW-1:0] FULL     = CW'(buff_size);
  localparam logic [SW-1:0] LAST_BUF = SW'(buff_size - 1);
  localparam logic [CW:0]   BS_WIDE  = (CW+1)'(buff_size);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SWEEP   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] rows_avail;
  logic [CW-1:0] rows_avail_nxt;
  logic [SW-1:0] rot;
  logic [SW-1:0] rot_nxt;
  logic [SW-1:0] wsel_nxt;
  logic [CW:0]   wsel_sum;
  logic [AW-1:0] out_row;
  logic          ld;
  logic          release_row;
  logic          release_frame;
  logic          accept_row;
  logic          overflow_evt;
  logic [buff_size-1:0][buff_size-1:0][input_width-1:0] win_nxt;

  // Release pulses are decoded from the RELEASE state itself so the
  // rows_avail decrement is already registered when IDLE next looks at it.
  always_comb begin
    release_row    = (state == RELEASE) && (out_row < LAST_POS);
    release_frame  = (state == RELEASE) && !(out_row < LAST_POS);
    row_free_o     = release_row;
    frame_done_o   = release_frame;
    accept_row     = row_done_i && ((rows_avail != FULL) || release_row);
    overflow_evt   = row_done_i && !accept_row;
    ld             = (state == SWEEP) && (!window_valid_o || window_ready_i);

    rows_avail_nxt = rows_avail;
    rot_nxt        = rot;
    if (release_frame) begin
      rows_avail_nxt = '0;
      rot_nxt        = '0;
    end else begin
      if (accept_row && !release_row) begin
        rows_avail_nxt = rows_avail + 1'b1;
      end else if (!accept_row && release_row) begin
        rows_avail_nxt = rows_avail - 1'b1;
      end
      if (release_row) begin
        rot_nxt = (rot == LAST_BUF) ? '0 : rot + 1'b1;
      end
    end

    // (rot + rows_avail) mod buff_size; the sum never reaches 2*buff_size.
    wsel_sum = (CW+1)'(rows_avail_nxt) + (CW+1)'(rot_nxt);
    wsel_nxt = (wsel_sum >= BS_WIDE) ? SW'(wsel_sum - BS_WIDE) : SW'(wsel_sum);
  end

  // Reorder buffers so window row 0 is the oldest line, and reverse the
  // per-buffer tap order so column 0 is the leftmost pixel.
  always_comb begin
    int unsigned src;
    src     = 0;
    win_nxt = '0;
    for (int unsigned r = 0; r < buff_size; r++) begin
      src = 32'(rot) + r;
      if (src >= buff_size) begin
        src = src - buff_size;
      end
      for (int unsigned c = 0; c < buff_size; c++) begin
        win_nxt[r][c] = rows_i[SW'(src)][SW'(buff_size - 1 - c)];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      rows_avail     <= '0;
      rot            <= '0;
      out_row        <= '0;
      read_address_o <= '0;
      row_wsel_o     <= '0;
      window_o       <= '0;
      window_valid_o <= 1'b0;
      overflow_o     <= 1'b0;
    end else begin
      rows_avail <= rows_avail_nxt;
      rot        <= rot_nxt;
      row_wsel_o <= wsel_nxt;

      if (overflow_evt) begin
        overflow_o <= 1'b1;
      end

      if (ld) begin
        window_o       <= win_nxt;
        window_valid_o <= 1'b1;
      end else if (window_valid_o && window_ready_i) begin
        window_valid_o <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (rows_avail == FULL) begin
            state <= SWEEP;
          end
        end
        SWEEP: begin
          if (ld) begin
            if (read_address_o == LAST_POS) begin
              state          <= RELEASE;
              read_address_o <= '0;
            end else begin
              read_address_o <= read_address_o + 1'b1;
            end
          end
        end
        RELEASE: begin
          if (out_row < LAST_POS) begin
            out_row <= out_row + 1'b1;
          end else begin
            out_row <= '0;
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_reader.sv
// Self-checking bench for conv_window_reader: a line-buffer memory model
// drives rows_i, an upstream model writes image rows on credit, and every
// accepted window is compared with the window cut directly from the image.
module tb_conv_window_reader;

  localparam int IW = 8;
  localparam int BS = 3;
  localparam int IM = 28;
  localparam int NW = IM - BS + 1;
  localparam int AW = $clog2(IM);
  localparam int SW = $clog2(BS);

  typedef logic [BS-1:0][BS-1:0][IW-1:0] win_t;

  typedef struct {
    int n_rows;
    int rdy_mode;
    int rand_img;
    int exp_windows;
    int exp_frees;
    int exp_fdone;
    int exp_wsel;
  } scen_t;

  logic          clk;
  logic          rst_i;
  logic          row_done_i;
  win_t          rows_i;
  logic [AW-1:0] read_address_o;
  logic [SW-1:0] row_wsel_o;
  logic          row_free_o;
  win_t          window_o;
  logic          window_valid_o;
  logic          window_ready_i;
  logic          frame_done_o;
  logic          overflow_o;

  logic [IW-1:0] img     [IM][IM];
  logic [IW-1:0] buf_mem [BS][IM];

  int n_checks;
  int n_fail;
  int acc_cnt;
  int free_cnt;
  int fdone_cnt;
  int rdy_mode;
  logic prev_stall;
  win_t prev_win;
  scen_t tbl [5];

  conv_window_reader #(
    .input_width (IW),
    .buff_size   (BS),
    .im_dim      (IM)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .row_done_i     (row_done_i),
    .rows_i         (rows_i),
    .read_address_o (read_address_o),
    .row_wsel_o     (row_wsel_o),
    .row_free_o     (row_free_o),
    .window_o       (window_o),
    .window_valid_o (window_valid_o),
    .window_ready_i (window_ready_i),
    .frame_done_o   (frame_done_o),
    .overflow_o     (overflow_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Line buffer memory: combinational read at read_address + BS-1-i.
  always_comb begin
    int idx;
    idx    = 0;
    rows_i = '0;
    for (int b = 0; b < BS; b++) begin
      for (int i = 0; i < BS; i++) begin
        idx = int'(read_address_o) + BS - 1 - i;
        if (idx < IM) rows_i[b][i] = buf_mem[b][idx];
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Window k of a frame, in raster order, cut straight from the image.
  function automatic win_t exp_win(input int k);
    win_t w;
    int wr;
    int col;
    w = '0;
    if (k >= NW * NW) return w;
    wr  = k / NW;
    col = k % NW;
    for (int r = 0; r < BS; r++)
      for (int c = 0; c < BS; c++)
        w[r][c] = img[wr + r][col + c];
    return w;
  endfunction

  // Downstream ready driver: 0 = always ready, 1 = toggle, 2 = random.
  initial begin
    window_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       window_ready_i = 1'b1;
        1:       window_ready_i = ~window_ready_i;
        default: window_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Downstream monitor: checks accepted windows in order and hold-while-stalled.
  initial begin
    prev_stall = 1'b0;
    prev_win   = '0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", window_valid_o, 1);
          check("stall_hold", window_o, prev_win);
        end
        if (row_free_o) free_cnt++;
        if (frame_done_o) fdone_cnt++;
        if (window_valid_o && window_ready_i) begin
          check("window", window_o, exp_win(acc_cnt));
          acc_cnt++;
        end
        prev_stall = window_valid_o && !window_ready_i;
        prev_win   = window_o;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic fill_pattern();
    for (int y = 0; y < IM; y++)
      for (int x = 0; x < IM; x++)
        img[y][x] = IW'(16 * y + x);
  endtask

  task automatic fill_random();
    for (int y = 0; y < IM; y++)
      for (int x = 0; x < IM; x++)
        img[y][x] = IW'($urandom);
  endtask

  task automatic do_reset();
    rst_i      = 1'b1;
    row_done_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i     = 1'b0;
    acc_cnt   = 0;
    free_cnt  = 0;
    fdone_cnt = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"}, read_address_o, 0);
    check({tag, "_wsel"}, row_wsel_o, 0);
    check({tag, "_free"}, row_free_o, 0);
    check({tag, "_window"}, window_o, 0);
    check({tag, "_valid"}, window_valid_o, 0);
    check({tag, "_fdone"}, frame_done_o, 0);
    check({tag, "_ovf"}, overflow_o, 0);
  endtask

  // Upstream writes image row y into its buffer (row y lives in buffer y mod BS).
  task automatic write_row(input int y);
    for (int x = 0; x < IM; x++) buf_mem[y % BS][x] = img[y][x];
    check("row_wsel", row_wsel_o, y % BS);
  endtask

  // Called at posedge+1; pulse lasts one cycle.
  task automatic pulse_row(input int y);
    write_row(y);
    row_done_i = 1'b1;
    @(posedge clk);
    #1;
    row_done_i = 1'b0;
  endtask

  task automatic wait_accepts(input int target, input int budget);
    int n;
    n = 0;
    while (acc_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", acc_cnt >= target, 1);
  endtask

  task automatic wait_addr(input int a);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (int'(read_address_o) != a && n < 200);
    check("addr_reach", read_address_o, a);
  endtask

  // Upstream model with credits: starts with BS free buffers, regains one per row_free_o.
  task automatic run_frame(input int n_rows, input int exp_w);
    int credits;
    int y;
    int settle;
    int cyc;
    credits = BS;
    y       = 0;
    settle  = 0;
    cyc     = 0;
    while (settle < 10 && cyc < 8000) begin
      @(posedge clk);
      #1;
      row_done_i = 1'b0;
      if (row_free_o) credits++;
      if (y < n_rows && credits > 0) begin
        write_row(y);
        row_done_i = 1'b1;
        credits--;
        y++;
      end
      if (y == n_rows && acc_cnt >= exp_w) settle++;
      cyc++;
    end
    row_done_i = 1'b0;
    check("frame_timeout", settle, 10);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    acc_cnt    = 0;
    free_cnt   = 0;
    fdone_cnt  = 0;
    rdy_mode   = 0;
    rst_i      = 1'b1;
    row_done_i = 1'b0;
    for (int b = 0; b < BS; b++)
      for (int x = 0; x < IM; x++)
        buf_mem[b][x] = '0;

    tbl[0] = '{n_rows: 3,  rdy_mode: 0, rand_img: 0, exp_windows: NW,      exp_frees: 1,      exp_fdone: 0, exp_wsel: 0};
    tbl[1] = '{n_rows: 3,  rdy_mode: 1, rand_img: 0, exp_windows: NW,      exp_frees: 1,      exp_fdone: 0, exp_wsel: 0};
    tbl[2] = '{n_rows: 3,  rdy_mode: 2, rand_img: 1, exp_windows: NW,      exp_frees: 1,      exp_fdone: 0, exp_wsel: 0};
    tbl[3] = '{n_rows: IM, rdy_mode: 0, rand_img: 0, exp_windows: NW * NW, exp_frees: IM - BS, exp_fdone: 1, exp_wsel: 0};
    tbl[4] = '{n_rows: IM, rdy_mode: 2, rand_img: 1, exp_windows: NW * NW, exp_frees: IM - BS, exp_fdone: 1, exp_wsel: 0};

    // Sequence A: reset values, latency, address sweep, rotation after a free.
    fill_pattern();
    rdy_mode = 0;
    do_reset();
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    pulse_row(0);
    pulse_row(1);
    pulse_row(2);
    @(negedge clk);
    check("lat_valid0", window_valid_o, 0);
    @(posedge clk);
    @(negedge clk);
    check("lat_valid1", window_valid_o, 0);
    check("sweep_addr0", read_address_o, 0);
    for (int k = 0; k < NW; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("sweep_valid", window_valid_o, 1);
      check("sweep_window", window_o, exp_win(k));
      check("sweep_addr", read_address_o, (k < NW - 1) ? k + 1 : 0);
    end
    check("free_pulse", row_free_o, 1);
    @(posedge clk);
    @(negedge clk);
    check("free_end", row_free_o, 0);
    check("wsel_after_free", row_wsel_o, 0);
    check("valid_drained", window_valid_o, 0);
    @(posedge clk);
    #1;
    pulse_row(3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rot_valid", window_valid_o, 1);
    check("rot_window", window_o, exp_win(NW));
    wait_accepts(2 * NW, 200);

    // Sequence B: row_done_i while full sets sticky overflow, windows unaffected.
    fill_pattern();
    do_reset();
    @(posedge clk);
    #1;
    pulse_row(0);
    pulse_row(1);
    pulse_row(2);
    wait_addr(5);
    check("ovf_before", overflow_o, 0);
    row_done_i = 1'b1;
    @(negedge clk);
    row_done_i = 1'b0;
    check("ovf_set", overflow_o, 1);
    wait_accepts(NW, 200);
    repeat (5) @(negedge clk);
    check("ovf_sticky", overflow_o, 1);
    check("ovf_frees", free_cnt, 1);
    check("ovf_wsel", row_wsel_o, 0);

    // Sequence C: reset mid-sweep, then a clean restart.
    do_reset();
    @(posedge clk);
    #1;
    pulse_row(0);
    pulse_row(1);
    pulse_row(2);
    wait_addr(10);
    rst_i = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    rst_i     = 1'b0;
    acc_cnt   = 0;
    free_cnt  = 0;
    fdone_cnt = 0;
    @(negedge clk);
    check("midrst_idle_valid", window_valid_o, 0);
    check("midrst_idle_addr", read_address_o, 0);
    @(posedge clk);
    #1;
    pulse_row(0);
    pulse_row(1);
    pulse_row(2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("restart_valid", window_valid_o, 1);
    check("restart_window", window_o, exp_win(0));
    check("restart_addr", read_address_o, 1);
    wait_accepts(NW, 200);

    // Table-driven frames, including randomized images and ready patterns.
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].rand_img != 0) fill_random();
      else fill_pattern();
      rdy_mode = tbl[i].rdy_mode;
      do_reset();
      run_frame(tbl[i].n_rows, tbl[i].exp_windows);
      check($sformatf("t%0d_windows", i), acc_cnt, tbl[i].exp_windows);
      check($sformatf("t%0d_frees", i), free_cnt, tbl[i].exp_frees);
      check($sformatf("t%0d_fdone", i), fdone_cnt, tbl[i].exp_fdone);
      check($sformatf("t%0d_wsel", i), row_wsel_o, tbl[i].exp_wsel);
      check($sformatf("t%0d_addr", i), read_address_o, 0);
      check($sformatf("t%0d_ovf", i), overflow_o, 0);
    end

    rdy_mode = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
